// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types and constants for the common data bus arbiter
package cdb_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int ROB_SIZE        = 16;
  localparam int DATA_WIDTH      = 64;
  localparam int PTR_W           = $clog2(ROB_SIZE);

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef enum logic {
    ST_IDLE,
    ST_PAIR2
  } cdb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [PTR_W-1:0]      rob_ptr;
    logic [DATA_WIDTH-1:0] value;
    logic [3:0]            nzcv;
    logic                  set_nzcv;
  } cdb_bcast_t;

  // Second beat of a pair targets the next ROB slot, wrapping at the end of the ROB.
  function automatic logic [PTR_W-1:0] next_rob_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester and broadcast signals of the common data bus
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
);

  logic [NUM_REQ-1:0]                 req_valid_in;
  logic [NUM_REQ-1:0]                 req_pair_in;
  logic [NUM_REQ-1:0][PTR_W-1:0]      req_rob_ptr_in;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_value_in;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_value2_in;
  logic [NUM_REQ-1:0][3:0]            req_nzcv_in;
  logic [NUM_REQ-1:0]                 req_set_nzcv_in;

  logic [NUM_REQ-1:0]                 grant_out;
  logic                               cdb_valid_out;
  logic [PTR_W-1:0]                   cdb_rob_ptr_out;
  logic [DATA_WIDTH-1:0]              cdb_value_out;
  logic [3:0]                         cdb_nzcv_out;
  logic                               cdb_set_nzcv_out;

  // Execution units and CDB consumers
  modport master (
    output req_valid_in, req_pair_in, req_rob_ptr_in, req_value_in,
           req_value2_in, req_nzcv_in, req_set_nzcv_in,
    input  grant_out, cdb_valid_out, cdb_rob_ptr_out, cdb_value_out,
           cdb_nzcv_out, cdb_set_nzcv_out
  );

  // The arbiter
  modport slave (
    input  req_valid_in, req_pair_in, req_rob_ptr_in, req_value_in,
           req_value2_in, req_nzcv_in, req_set_nzcv_in,
    output grant_out, cdb_valid_out, cdb_rob_ptr_out, cdb_value_out,
           cdb_nzcv_out, cdb_set_nzcv_out
  );

endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// rtl/cdb_arbiter_rr_priority_picker.sv - first valid request at or after the pointer, one-hot
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  int               idx;
  logic [IDX_W-1:0] idx_v;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_v  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = IDX_W'(idx);
      if (!found && req[idx_v]) begin
        found        = 1'b1;
        grant[idx_v] = 1'b1;
        winner       = idx_v;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter for the common data bus with two-beat pair sequencing
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input logic         clk_in,
  input logic         rst_in_N,
  input logic         flush_in,
  input logic         halt_in,
  cdb_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  cdb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  cdb_bcast_t            bcast_q, bcast_d;
  logic [PTR_W-1:0]      pair_ptr_q, pair_ptr_d;
  logic [DATA_WIDTH-1:0] pair_val_q, pair_val_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      winner;
  logic                  found;
  logic                  grant_en;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (bus.req_valid_in),
    .ptr    (rr_q),
    .grant  (pick_grant),
    .winner (winner),
    .found  (found)
  );

  // Grants are only offered when the bus is free next cycle and nothing is being squashed.
  assign grant_en      = rst_in_N && (state_q == ST_IDLE) && !flush_in && !halt_in;
  assign bus.grant_out = grant_en ? pick_grant : '0;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    bcast_d       = bcast_q;
    bcast_d.valid = 1'b0;
    pair_ptr_d    = pair_ptr_q;
    pair_val_d    = pair_val_q;

    if (flush_in) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_PAIR2) begin
      // Halt does not stop a pair already in flight.
      bcast_d.valid    = 1'b1;
      bcast_d.rob_ptr  = pair_ptr_q;
      bcast_d.value    = pair_val_q;
      bcast_d.nzcv     = 4'h0;
      bcast_d.set_nzcv = 1'b0;
      state_d          = ST_IDLE;
    end else if (grant_en && found) begin
      bcast_d.valid    = 1'b1;
      bcast_d.rob_ptr  = bus.req_rob_ptr_in[winner];
      bcast_d.value    = bus.req_value_in[winner];
      bcast_d.nzcv     = bus.req_nzcv_in[winner];
      bcast_d.set_nzcv = bus.req_set_nzcv_in[winner];
      rr_d             = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
      if (bus.req_pair_in[winner]) begin
        state_d    = ST_PAIR2;
        pair_ptr_d = next_rob_ptr(bus.req_rob_ptr_in[winner]);
        pair_val_d = bus.req_value2_in[winner];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_N) begin
    if (!rst_in_N) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      bcast_q    <= '0;
      pair_ptr_q <= '0;
      pair_val_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      bcast_q    <= bcast_d;
      pair_ptr_q <= pair_ptr_d;
      pair_val_q <= pair_val_d;
    end
  end

  assign bus.cdb_valid_out    = bcast_q.valid;
  assign bus.cdb_rob_ptr_out  = bcast_q.rob_ptr;
  assign bus.cdb_value_out    = bcast_q.value;
  assign bus.cdb_nzcv_out     = bcast_q.nzcv;
  assign bus.cdb_set_nzcv_out = bcast_q.set_nzcv;

  a_grant_onehot0: assert property (@(posedge clk_in) disable iff (!rst_in_N)
    $onehot0(bus.grant_out));

  a_no_grant_in_pair2: assert property (@(posedge clk_in) disable iff (!rst_in_N)
    (state_q == ST_PAIR2) |-> (bus.grant_out == '0));

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the execution-unit requesters (ALU, load/store unit, future units).
- Each cycle it grants at most one requester, registers the winner's result and broadcasts it to the reservation stations, ROB writeback and register-file wakeup.
- Replaces the fixed ALU/LS alternation in execute with round-robin arbitration.
- Sequences two-beat results (load pair) on consecutive cycles and supports flush on mispredict and halt.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 = ALU, 1 = LSU.
- ROB_SIZE, 16, ROB entries; the pointer width is $clog2(ROB_SIZE).
- DATA_WIDTH, 64, result width.

Ports:
- clk_in  input  1  clock.
- rst_in_N  input  1  reset, asynchronous, active-low.
- flush_in  input  1  mispredict flush from commit.
- halt_in  input  1  CPU halted; no new grants.
- req_valid_in  input  NUM_REQ  requester i has a result.
- req_pair_in  input  NUM_REQ  result has a second beat.
- req_rob_ptr_in  input  NUM_REQ x $clog2(ROB_SIZE)  destination ROB index.
- req_value_in  input  NUM_REQ x DATA_WIDTH  first-beat value.
- req_value2_in  input  NUM_REQ x DATA_WIDTH  second-beat value.
- req_nzcv_in  input  NUM_REQ x 4  flags.
- req_set_nzcv_in  input  NUM_REQ  result writes NZCV.
- grant_out  output  NUM_REQ  one-hot, combinational; requester may drop its request next cycle.
- cdb_valid_out  output  1  broadcast valid.
- cdb_rob_ptr_out  output  $clog2(ROB_SIZE)  broadcast ROB index.
- cdb_value_out  output  DATA_WIDTH  broadcast value.
- cdb_nzcv_out  output  4  broadcast flags.
- cdb_set_nzcv_out  output  1  flags valid.

Behaviour:
- Reset (async, rst_in_N=0):
  - cdb_valid_out=0, cdb_rob_ptr_out=0, cdb_value_out=0, cdb_nzcv_out=0, cdb_set_nzcv_out=0.
  - Round-robin pointer = 0; state = IDLE; latched second beat cleared.
  - grant_out=0 while reset is asserted.
- Requesters hold valid and payload stable until granted; the payload is sampled in the grant cycle.
- States:
  - IDLE: grant eligible.
  - PAIR2: second beat pending; grant_out forced to 0.
- Grant in IDLE, when !flush_in && !halt_in:
  - Pick the first valid requester scanning from rr_ptr upward, modulo NUM_REQ.
  - rr_ptr <= winner+1 mod NUM_REQ. With no request, rr_ptr holds.
- Latency: a grant at cycle t puts the beat-0 payload on the CDB at t+1 (registered).
  - Pair request: beat 0 at t+1; beat 1 at t+2 with rob_ptr = (ptr+1) mod ROB_SIZE, value = value2, nzcv=0, set_nzcv=0.
  - Transitions: IDLE->PAIR2 at t+1, PAIR2->IDLE at t+2.
  - value2 and ptr are latched at grant time.
- Non-grant cycles: cdb_valid_out=0 next cycle. Data outputs hold their last value and are don't-care when valid=0.
- ROB pointer wrap: ptr=ROB_SIZE-1 gives a second beat of 0.
- flush_in:
  - No grant in that cycle; next cycle cdb_valid_out=0; PAIR2->IDLE (second beat dropped); rr_ptr unchanged.
  - A beat registered in the cycle before the flush still appears on the CDB.
- halt_in:
  - No new grants; a pending PAIR2 beat still completes.
  - Flush and halt together: flush wins.
- Fairness: with all requesters continuously valid, each is granted at least once every NUM_REQ grant cycles.
- A single requester valid every cycle is granted every eligible cycle, giving one CDB beat per cycle.
- Reset mid-pair: the second beat is never driven.

Decomposition:
- Shared package: cdb_bcast_t struct {valid, rob_ptr, value, nzcv, set_nzcv}, ROB_SIZE, DATA_WIDTH, requester-index constants REQ_ALU=0, REQ_LSU=1.
- Sub-module rr_priority_picker (combinational, one-hot grant from request vector and pointer); the FSM and output registers stay in cdb_arbiter.

Test Plan:
1. Reset then idle:
   - Stimulus: assert rst_in_N=0 mid-run, release, hold no requests.
   - Response: all outputs 0 immediately; cdb_valid_out stays 0.
2. Contention:
   - Stimulus: ALU and LSU both valid every cycle, rr_ptr=0, distinct ptrs 3/5.
   - Response: grants alternate 01,10,01; CDB ptrs 3,5,3 starting one cycle later.
3. Load pair:
   - Stimulus: LSU pair with ptr=15, values 0xAA/0xBB; ALU also valid.
   - Response: CDB (15,0xAA) then (0,0xBB); no ALU grant during PAIR2; ALU granted the following cycle.
4. Flush during PAIR2:
   - Stimulus: assert flush_in the cycle beat 0 is on the CDB.
   - Response: no beat 1; cdb_valid_out=0 next cycle; no grant in the flush cycle.
5. Halt:
   - Stimulus: assert halt_in with both requesters valid.
   - Response: grant_out=0 while halted; on deassert, the winner is the requester at the unchanged rr_ptr.
6. Single requester:
   - Stimulus: ALU valid for 4 cycles, ptrs 1,2,3,4.
   - Response: 4 consecutive CDB beats 1,2,3,4, each one cycle after its grant.
